// File: rtl/gpu_fb_write_ctrl.sv
// Framebuffer write controller: rasteriser pixels -> FIFO -> async SRAM write cycles, double buffered.
// Latency: pixel accepted at edge N shows SETUP after N+2; each write occupies WR_CYCLES+2 cycles.
// Backpressure: pix_ready_o is low while the pixel FIFO is full or a buffer swap is pending.

// Generic synchronous FIFO with combinational head read; DEPTH must be a power of two.
module gpu_fb_fifo #(
  parameter int DAT_W = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [DAT_W-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [DAT_W-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign push   = wr_vld && !full;
  assign pop    = rd_rdy && !empty;
  assign rd_dat = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

module gpu_fb_write_ctrl #(
  parameter int CHANNEL_BITS = 8,
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 9,
  parameter int ADDR_BITS    = 20,
  parameter int FIFO_DEPTH   = 8,
  parameter int WR_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid_i,
  output logic                      pix_ready_o,
  input  logic [X_BITS-1:0]         pix_x_i,
  input  logic [Y_BITS-1:0]         pix_y_i,
  input  logic [3*CHANNEL_BITS-1:0] pix_rgb_i,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic                      disp_bank_o,
  output logic [ADDR_BITS-1:0]      sram_addr_o,
  output logic [3*CHANNEL_BITS-1:0] sram_data_o,
  output logic                      sram_ce_n_o,
  output logic                      sram_we_n_o,
  output logic                      sram_oe_n_o,
  output logic                      sram_lb_n_o,
  output logic                      sram_ub_n_o,
  output logic [15:0]               drop_cnt_o
);
  localparam int RGB_W = 3 * CHANNEL_BITS;
  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_SWAP   = 3'd4;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [RGB_W-1:0]     rgb;
  } fb_ent_t;

  logic [2:0]           state;
  logic [CNT_W-1:0]     strobe_cnt;
  logic                 wr_bank;
  logic                 flush_pending;
  logic                 flush_done_q;
  logic                 fifo_ne_q;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pix_fire;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic                 swap_ok;
  logic                 ce_n;
  logic [15:0]          drop_cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [RGB_W-1:0]     data_q;
  fb_ent_t              in_ent;
  fb_ent_t              head_ent;

  assign pix_ready_o = !fifo_full && !flush_pending;
  assign pix_fire    = pix_valid_i && pix_ready_o;
  assign in_range    = (32'(pix_x_i) < WIDTH) && (32'(pix_y_i) < HEIGHT);
  assign push        = pix_fire && in_range;

  // Bank offset is folded in at enqueue, so the entry is already final when popped.
  assign in_ent.addr = ADDR_BITS'(pix_y_i) * ADDR_BITS'(WIDTH) + ADDR_BITS'(pix_x_i)
                     + (wr_bank ? ADDR_BITS'(WIDTH * HEIGHT) : '0);
  assign in_ent.rgb  = pix_rgb_i;

  // The FSM looks at a registered not-empty flag: an entry becomes eligible one cycle
  // after it is written. Only IDLE/HOLD pop, and never two cycles running, so the
  // delayed flag can never claim an entry that has already been taken.
  assign pop     = ((state == S_IDLE) || (state == S_HOLD)) && fifo_ne_q;
  assign swap_ok = !fifo_ne_q && fifo_empty && flush_pending;

  gpu_fb_fifo #(
    .DAT_W ($bits(fb_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (in_ent),
    .rd_rdy (pop),
    .rd_dat (head_ent),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Delayed FIFO occupancy flag for the write sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fifo_ne_q <= 1'b0;
    else     fifo_ne_q <= !fifo_empty;
  end

  // Write sequencer: SETUP -> STROBE x WR_CYCLES -> HOLD, plus the bank swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      strobe_cnt   <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_bank      <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            addr_q <= head_ent.addr;
            data_q <= head_ent.rgb;
            state  <= S_SETUP;
          end else if (swap_ok) begin
            state <= S_SWAP;
          end
        end
        S_SETUP: begin
          strobe_cnt <= '0;
          state      <= S_STROBE;
        end
        S_STROBE: begin
          if (strobe_cnt == CNT_W'(WR_CYCLES - 1)) state <= S_HOLD;
          else strobe_cnt <= strobe_cnt + CNT_W'(1);
        end
        S_HOLD: begin
          if (pop) begin
            addr_q <= head_ent.addr;
            data_q <= head_ent.rgb;
            state  <= S_SETUP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SWAP: begin
          wr_bank      <= ~wr_bank;
          flush_done_q <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flush request latch; repeated requests merge until the swap clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  flush_pending <= 1'b0;
    else if (state == S_SWAP) flush_pending <= 1'b0;
    else if (flush_i)         flush_pending <= 1'b1;
  end

  // Saturating count of accepted but off-screen pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         drop_cnt <= '0;
    else if (pix_fire && !in_range && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  // Strobes decode straight from state so reset deasserts them immediately.
  assign ce_n         = !((state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD));
  assign sram_ce_n_o  = ce_n;
  assign sram_we_n_o  = (state != S_STROBE);
  assign sram_oe_n_o  = 1'b1;
  assign sram_lb_n_o  = ce_n;
  assign sram_ub_n_o  = ce_n;
  assign sram_addr_o  = addr_q;
  assign sram_data_o  = data_q;
  assign flush_done_o = flush_done_q;
  assign disp_bank_o  = ~wr_bank;
  assign drop_cnt_o   = drop_cnt;
endmodule

// File: tb/tb_gpu_fb_write_ctrl.sv
// Bench for gpu_fb_write_ctrl: directed scenarios plus random pixel/flush traffic.
// Reference model tracks frames, banks and expected SRAM writes as plain queues.
// Outputs sampled on the falling edge or 1ns after the rising edge.
module tb_gpu_fb_write_ctrl;
  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid;
  logic        pix_ready_o;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        flush_i;
  logic        flush_done_o;
  logic        disp_bank_o;
  logic [19:0] sram_addr_o;
  logic [23:0] sram_data_o;
  logic        sram_ce_n_o, sram_we_n_o, sram_oe_n_o, sram_lb_n_o, sram_ub_n_o;
  logic [15:0] drop_cnt_o;

  always #5 clk = ~clk;

  gpu_fb_write_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid_i  (pix_valid),
    .pix_ready_o  (pix_ready_o),
    .pix_x_i      (pix_x),
    .pix_y_i      (pix_y),
    .pix_rgb_i    (pix_rgb),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .disp_bank_o  (disp_bank_o),
    .sram_addr_o  (sram_addr_o),
    .sram_data_o  (sram_data_o),
    .sram_ce_n_o  (sram_ce_n_o),
    .sram_we_n_o  (sram_we_n_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_lb_n_o  (sram_lb_n_o),
    .sram_ub_n_o  (sram_ub_n_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model state
  int unsigned q_addr[$];
  int unsigned q_rgb[$];
  int          wr_t[$];
  int          m_drop, m_swaps, n_done, n_wr, n_stall, cyc, we_len;
  bit          m_bank, m_pend, prev_we;
  int unsigned last_addr;

  function automatic int unsigned lin(input int x, input int y, input bit bank);
    return y * W + x + (bank ? W * H : 0);
  endfunction

  // Model and SRAM-side monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_rgb.delete();
      m_drop  = 0;
      m_swaps = 0;
      n_done  = 0;
      m_bank  = 1'b0;
      m_pend  = 1'b0;
      prev_we = 1'b1;
      we_len  = 0;
    end else begin
      if (flush_done_o) begin
        n_done++;
        m_pend = 1'b0;
        check("swap_drained", q_addr.size(), 0);
        check("swap_disp_bank", disp_bank_o, !m_bank);
      end
      if (m_pend) check("ready_while_pending", pix_ready_o, 0);
      if (pix_valid && pix_ready_o) begin
        if (pix_x >= W || pix_y >= H) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          q_addr.push_back(lin(pix_x, pix_y, m_bank));
          q_rgb.push_back(pix_rgb);
        end
      end
      if (flush_i && !m_pend) begin
        m_pend = 1'b1;
        m_bank = !m_bank;
        m_swaps++;
      end
      check("lb_ub", {sram_lb_n_o, sram_ub_n_o}, {sram_ce_n_o, sram_ce_n_o});
      if (!sram_we_n_o) begin
        if (prev_we) begin
          n_wr++;
          wr_t.push_back(cyc);
          last_addr = sram_addr_o;
          check("strobe_ce", sram_ce_n_o, 0);
          check("wr_expected", q_addr.size() != 0, 1);
          if (q_addr.size() != 0) begin
            check("wr_addr", sram_addr_o, q_addr.pop_front());
            check("wr_data", sram_data_o, q_rgb.pop_front());
          end
        end
        we_len++;
      end else if (!prev_we) begin
        check("we_len", we_len, 2);
        we_len = 0;
      end
      prev_we = sram_we_n_o;
    end
  end

  task automatic send_pix(input int x, input int y, input int unsigned rgb);
    bit acc;
    acc = 1'b0;
    pix_x = 10'(x);
    pix_y = 9'(y);
    pix_rgb = 24'(rgb);
    pix_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = pix_ready_o;
      if (!acc) n_stall++;
      @(posedge clk);
      #1;
    end
    check("send_accept", acc, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(posedge clk);
      #1;
      done = (q_addr.size() == 0) && sram_ce_n_o && !m_pend;
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_ce"}, sram_ce_n_o, 1);
    check({p, "_we"}, sram_we_n_o, 1);
    check({p, "_oe"}, sram_oe_n_o, 1);
    check({p, "_lbub"}, {sram_lb_n_o, sram_ub_n_o}, 2'b11);
    check({p, "_addr"}, sram_addr_o, 0);
    check({p, "_data"}, sram_data_o, 0);
    check({p, "_disp"}, disp_bank_o, 1);
    check({p, "_fdone"}, flush_done_o, 0);
    check({p, "_drop"}, drop_cnt_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw0, d0, bad;
    bit got;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_rgb = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst0");
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", pix_ready_o, 1);

    // Single pixel: cycle-accurate SETUP/STROBE/HOLD sequence
    pix_x = 10'd3; pix_y = 9'd2; pix_rgb = 24'hA5C3F0; pix_valid = 1'b1;
    check("t1_ready", pix_ready_o, 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("t1_ce_k%0d", k), sram_ce_n_o, (k >= 2 && k <= 5) ? 0 : 1);
      check($sformatf("t1_we_k%0d", k), sram_we_n_o, (k == 3 || k == 4) ? 0 : 1);
      if (k >= 2 && k <= 5) begin
        check($sformatf("t1_addr_k%0d", k), sram_addr_o, 1283);
        check($sformatf("t1_data_k%0d", k), sram_data_o, 24'hA5C3F0);
      end
    end

    // Stream of 20 pixels with valid held high
    n_stall = 0;
    wr_t.delete();
    for (int i = 0; i < 20; i++)
      send_pix($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom);
    pix_valid = 1'b0;
    wait_idle("stream_drain", 400);
    check("stream_count", wr_t.size(), 20);
    check("stream_stalled", n_stall > 0, 1);
    bad = 0;
    for (int i = 1; i < wr_t.size(); i++) if (wr_t[i] - wr_t[i-1] != 4) bad++;
    check("stream_gap", bad, 0);

    // Range boundaries
    nw0 = n_wr;
    send_pix(640, 0, 24'h111111);
    send_pix(0, 480, 24'h222222);
    send_pix(639, 479, 24'h333333);
    pix_valid = 1'b0;
    wait_idle("bound_drain", 100);
    check("bound_drop", drop_cnt_o, 2);
    check("bound_writes", n_wr - nw0, 1);
    check("bound_addr", last_addr, 307199);

    // Flush with three pixels queued; third pixel shares the flush cycle
    check("pre_flush_disp", disp_bank_o, 1);
    nw0 = n_wr;
    send_pix(10, 10, 24'h0A0A0A);
    send_pix(20, 20, 24'h141414);
    flush_i = 1'b1;
    send_pix(30, 30, 24'h1E1E1E);
    flush_i = 1'b0;
    pix_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(posedge clk); #1;
      if (flush_done_o) got = 1'b1;
      else check("flush_ready_low", pix_ready_o, 0);
    end
    check("flush_done_seen", got, 1);
    check("flush_writes", n_wr - nw0, 3);
    check("flush_disp_bank", disp_bank_o, 0);
    check("flush_ready_back", pix_ready_o, 1);
    send_pix(0, 0, 24'hCAFE00);
    pix_valid = 1'b0;
    wait_idle("bank1_drain", 100);
    check("bank1_addr", last_addr, 307200);

    // Two flush pulses two cycles apart merge into one swap
    d0 = n_done;
    flush_i = 1'b1; @(posedge clk); #1;
    flush_i = 1'b0; @(posedge clk); #1;
    flush_i = 1'b1; @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("dflush_count", n_done - d0, 1);
    check("dflush_disp", disp_bank_o, 1);

    // Reset in the middle of a strobe
    send_pix(5, 5, 24'h555555);
    pix_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = !sram_we_n_o;
    end
    check("rst_reach_strobe", got, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_we_now", sram_we_n_o, 1);
    check("rst_ce_now", sram_ce_n_o, 1);
    @(posedge clk); #1;
    check_reset_state("rst1");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst1_ready", pix_ready_o, 1);

    // Random traffic with off-screen pixels and occasional flushes
    for (int c = 0; c < 600; c++) begin
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_x = 10'($urandom_range(0, 700));
      pix_y = 9'($urandom_range(0, 511));
      pix_rgb = 24'($urandom);
      flush_i = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    flush_i = 1'b0;
    wait_idle("rand_drain", 3000);
    repeat (5) @(posedge clk);
    #1;
    check("rand_drop", drop_cnt_o, m_drop);
    check("rand_swaps", n_done, m_swaps);
    check("rand_disp", disp_bank_o, !m_bank);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
